// File: rtl/decode_pkg.sv
// decode_pkg: shared encodings for the ARM decode stage.
//   - ALUControl encoding driven to execute
//   - condition-code encoding of Instr[31:28]
//   - op (Instr[27:26]) and data-processing cmd (Instr[24:21]) values
//   - address of the PC alias in the register file
package decode_pkg;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_ORR = 3'b011,
        ALU_MOV = 3'b100
    } alu_ctrl_e;

    // 4'b1111 is deliberately absent: it never passes.
    typedef enum logic [3:0] {
        COND_EQ = 4'h0,
        COND_NE = 4'h1,
        COND_CS = 4'h2,
        COND_CC = 4'h3,
        COND_MI = 4'h4,
        COND_PL = 4'h5,
        COND_VS = 4'h6,
        COND_VC = 4'h7,
        COND_HI = 4'h8,
        COND_LS = 4'h9,
        COND_GE = 4'hA,
        COND_LT = 4'hB,
        COND_GT = 4'hC,
        COND_LE = 4'hD,
        COND_AL = 4'hE
    } cond_e;

    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;

    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_CMP = 4'b1010;
    localparam logic [3:0] CMD_ORR = 4'b1100;
    localparam logic [3:0] CMD_MOV = 4'b1101;

    localparam logic [3:0] REG_PC = 4'd15;

endpackage

// File: rtl/decode_stage_regfile.sv
// regfile: 15 x DATA_WIDTH register file (R0-R14) for the decode stage.
// Ports:
//   clk, reset       rising-edge clock, synchronous active-high reset (clears R0-R14)
//   RA1, RA2         combinational read addresses; address 15 returns PCPlus8
//   RD1, RD2         read data
//   WE3, WA3, WD3    write port; writes to address 15 are dropped (PC lives in fetch)
//   PCPlus8          value aliased onto R15
module regfile
    import decode_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [3:0]            RA1,
    input  logic [3:0]            RA2,
    input  logic                  WE3,
    input  logic [3:0]            WA3,
    input  logic [DATA_WIDTH-1:0] WD3,
    input  logic [DATA_WIDTH-1:0] PCPlus8,
    output logic [DATA_WIDTH-1:0] RD1,
    output logic [DATA_WIDTH-1:0] RD2
);

    logic [DATA_WIDTH-1:0] rf_q [0:14];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 15; i++) begin
                rf_q[i] <= '0;
            end
        end else if (WE3 && (WA3 != REG_PC)) begin
            rf_q[WA3] <= WD3;
        end
    end

    // No write-to-read bypass: a same-cycle read sees the pre-edge value.
    assign RD1 = (RA1 == REG_PC) ? PCPlus8 : rf_q[RA1];
    assign RD2 = (RA2 == REG_PC) ? PCPlus8 : rf_q[RA2];

endmodule

// File: rtl/decode_stage.sv
// decode_stage: decode stage of the single-cycle ARM datapath.
// Decodes Instr, reads operands, builds the extended immediate, evaluates the
// condition field against the NZCV flags register and produces gated control.
// Ports:
//   clk, reset                 rising-edge clock, synchronous active-high reset
//   Instr, PCPlus8             fetched instruction and the R15 read value
//   WE3, WA3, WD3              writeback port into the register file
//   ALUFlags                   NZCV from execute, captured on flag-setting ops
//   RD1, RD2, ExtImm           operands for execute
//   ALUControl, ALUSrc         ALU operation and B-operand select
//   RegWrite, MemWrite,
//   MemtoReg, PCSrc            control (write controls gated by CondEx)
//   CondEx, Flags              condition result and the registered NZCV
module decode_stage
    import decode_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [31:0]           Instr,
    input  logic [DATA_WIDTH-1:0] PCPlus8,
    input  logic                  WE3,
    input  logic [3:0]            WA3,
    input  logic [DATA_WIDTH-1:0] WD3,
    input  logic [3:0]            ALUFlags,
    output logic [DATA_WIDTH-1:0] RD1,
    output logic [DATA_WIDTH-1:0] RD2,
    output logic [DATA_WIDTH-1:0] ExtImm,
    output logic [2:0]            ALUControl,
    output logic                  ALUSrc,
    output logic                  RegWrite,
    output logic                  MemWrite,
    output logic                  MemtoReg,
    output logic                  PCSrc,
    output logic                  CondEx,
    output logic [3:0]            Flags
);

    logic [1:0]  op;
    logic [3:0]  cmd;
    logic [3:0]  rn;
    logic [3:0]  rd;
    logic [3:0]  ra2;
    logic        i_bit;
    logic        s_bit;

    assign op    = Instr[27:26];
    assign i_bit = Instr[25];
    assign cmd   = Instr[24:21];
    assign s_bit = Instr[20];
    assign rn    = Instr[19:16];
    assign rd    = Instr[15:12];

    alu_ctrl_e             alu_ctrl;
    logic                  alu_src;
    logic                  reg_w_pre;
    logic                  mem_w_pre;
    logic                  mem_to_reg;
    logic                  branch;
    logic                  flag_w_pre;
    logic                  ra2_is_rd;
    logic [DATA_WIDTH-1:0] ext_imm;

    // Data-processing immediate: imm8 rotated right by twice the rot field.
    logic [31:0] imm8_ext;
    logic [4:0]  rot_amt;
    logic [31:0] imm_rot;

    assign imm8_ext = {24'd0, Instr[7:0]};
    assign rot_amt  = {Instr[11:8], 1'b0};
    assign imm_rot  = (imm8_ext >> rot_amt) | (imm8_ext << (6'd32 - {1'b0, rot_amt}));

    always_comb begin
        alu_ctrl   = ALU_ADD;
        alu_src    = 1'b0;
        reg_w_pre  = 1'b0;
        mem_w_pre  = 1'b0;
        mem_to_reg = 1'b0;
        branch     = 1'b0;
        flag_w_pre = 1'b0;
        ra2_is_rd  = 1'b0;
        ext_imm    = '0;
        case (op)
            OP_DP: begin
                alu_src = i_bit;
                if (i_bit) begin
                    ext_imm = imm_rot;
                end
                case (cmd)
                    CMD_ADD: begin alu_ctrl = ALU_ADD; reg_w_pre = 1'b1; flag_w_pre = s_bit; end
                    CMD_SUB: begin alu_ctrl = ALU_SUB; reg_w_pre = 1'b1; flag_w_pre = s_bit; end
                    CMD_AND: begin alu_ctrl = ALU_AND; reg_w_pre = 1'b1; flag_w_pre = s_bit; end
                    CMD_ORR: begin alu_ctrl = ALU_ORR; reg_w_pre = 1'b1; flag_w_pre = s_bit; end
                    CMD_MOV: begin alu_ctrl = ALU_MOV; reg_w_pre = 1'b1; flag_w_pre = s_bit; end
                    // CMP always sets flags, whatever the S bit says.
                    CMD_CMP: begin alu_ctrl = ALU_SUB; flag_w_pre = 1'b1; end
                    default: ;
                endcase
            end
            OP_MEM: begin
                alu_src  = 1'b1;
                alu_ctrl = Instr[23] ? ALU_ADD : ALU_SUB;
                ext_imm  = {20'd0, Instr[11:0]};
                if (Instr[20]) begin
                    reg_w_pre  = 1'b1;
                    mem_to_reg = 1'b1;
                end else begin
                    mem_w_pre = 1'b1;
                    // STR needs the store data register on port 2.
                    ra2_is_rd = 1'b1;
                end
            end
            OP_BR: begin
                alu_src = 1'b1;
                branch  = 1'b1;
                ext_imm = {{6{Instr[23]}}, Instr[23:0], 2'b00};
            end
            default: ;
        endcase
    end

    assign ra2 = ra2_is_rd ? rd : Instr[3:0];

    regfile #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_regfile (
        .clk    (clk),
        .reset  (reset),
        .RA1    (rn),
        .RA2    (ra2),
        .WE3    (WE3),
        .WA3    (WA3),
        .WD3    (WD3),
        .PCPlus8(PCPlus8),
        .RD1    (RD1),
        .RD2    (RD2)
    );

    // Condition check against the registered NZCV.
    logic [3:0] flags_q;
    logic [3:0] flags_d;
    logic       n_f;
    logic       z_f;
    logic       c_f;
    logic       v_f;
    logic       cond_ok;

    assign {n_f, z_f, c_f, v_f} = flags_q;

    always_comb begin
        cond_ok = 1'b0;
        case (cond_e'(Instr[31:28]))
            COND_EQ: cond_ok = z_f;
            COND_NE: cond_ok = ~z_f;
            COND_CS: cond_ok = c_f;
            COND_CC: cond_ok = ~c_f;
            COND_MI: cond_ok = n_f;
            COND_PL: cond_ok = ~n_f;
            COND_VS: cond_ok = v_f;
            COND_VC: cond_ok = ~v_f;
            COND_HI: cond_ok = c_f & ~z_f;
            COND_LS: cond_ok = ~c_f | z_f;
            COND_GE: cond_ok = (n_f == v_f);
            COND_LT: cond_ok = (n_f != v_f);
            COND_GT: cond_ok = ~z_f & (n_f == v_f);
            COND_LE: cond_ok = z_f | (n_f != v_f);
            COND_AL: cond_ok = 1'b1;
            default: cond_ok = 1'b0;
        endcase
    end

    always_comb begin
        flags_d = flags_q;
        if (flag_w_pre && cond_ok) begin
            flags_d = ALUFlags;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            flags_q <= 4'b0000;
        end else begin
            flags_q <= flags_d;
        end
    end

    assign Flags      = flags_q;
    assign CondEx     = cond_ok;
    assign ALUControl = alu_ctrl;
    assign ALUSrc     = alu_src;
    assign ExtImm     = ext_imm;
    assign MemtoReg   = mem_to_reg;
    assign RegWrite   = reg_w_pre & cond_ok;
    assign MemWrite   = mem_w_pre & cond_ok;
    // A taken write to R15 redirects fetch just like a branch.
    assign PCSrc      = cond_ok & (branch | (reg_w_pre & (rd == REG_PC)));

endmodule

// File: tb/tb_decode_stage.sv
// Testbench for decode_stage: directed steps from the test plan followed by
// randomized instructions checked against a behavioural model.
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] Instr;
    logic [31:0] PCPlus8;
    logic        WE3;
    logic [3:0]  WA3;
    logic [31:0] WD3;
    logic [3:0]  ALUFlags;
    logic [31:0] RD1, RD2, ExtImm;
    logic [2:0]  ALUControl;
    logic        ALUSrc, RegWrite, MemWrite, MemtoReg, PCSrc, CondEx;
    logic [3:0]  Flags;

    decode_stage #(.DATA_WIDTH(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .Instr     (Instr),
        .PCPlus8   (PCPlus8),
        .WE3       (WE3),
        .WA3       (WA3),
        .WD3       (WD3),
        .ALUFlags  (ALUFlags),
        .RD1       (RD1),
        .RD2       (RD2),
        .ExtImm    (ExtImm),
        .ALUControl(ALUControl),
        .ALUSrc    (ALUSrc),
        .RegWrite  (RegWrite),
        .MemWrite  (MemWrite),
        .MemtoReg  (MemtoReg),
        .PCSrc     (PCSrc),
        .CondEx    (CondEx),
        .Flags     (Flags)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Reference state
    logic [31:0] m_rf [15];
    logic [3:0]  m_flags;

    // Reference outputs
    logic [31:0] e_rd1, e_rd2, e_ext;
    logic [2:0]  e_alu;
    bit          e_alusrc, e_regw, e_memw, e_m2r, e_pcsrc, e_cond, e_flagupd, e_ctl_known;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // ARM condition table, with flags as N,Z,C,V.
    function automatic bit cond_pass(input logic [3:0] c, input logic [3:0] f);
        bit n, z, cy, v;
        n = f[3]; z = f[2]; cy = f[1]; v = f[0];
        case (c)
            4'h0: return z;
            4'h1: return !z;
            4'h2: return cy;
            4'h3: return !cy;
            4'h4: return n;
            4'h5: return !n;
            4'h6: return v;
            4'h7: return !v;
            4'h8: return cy && !z;
            4'h9: return !cy || z;
            4'hA: return n == v;
            4'hB: return n != v;
            4'hC: return !z && (n == v);
            4'hD: return z || (n != v);
            4'hE: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // Rotate right one bit at a time.
    function automatic logic [31:0] ror_slow(input logic [31:0] x, input int n);
        logic [31:0] r;
        r = x;
        for (int k = 0; k < n; k++) r = {r[0], r[31:1]};
        return r;
    endfunction

    function automatic logic [31:0] rd_model(input logic [3:0] a);
        return (a == 4'd15) ? PCPlus8 : m_rf[a];
    endfunction

    task automatic model_eval();
        logic [1:0] op;
        logic [3:0] cmd, rn, rd, ra2;
        bit pass, wr, cmp;
        int v;
        op  = Instr[27:26];
        cmd = Instr[24:21];
        rn  = Instr[19:16];
        rd  = Instr[15:12];
        ra2 = Instr[3:0];
        pass = cond_pass(Instr[31:28], m_flags);
        e_cond = pass; e_ext = 32'd0; e_alu = 3'd0; e_alusrc = 0; e_regw = 0; e_memw = 0;
        e_m2r = 0; e_pcsrc = 0; e_flagupd = 0; e_ctl_known = 1;
        case (op)
            2'b00: begin
                wr = 1; cmp = 0;
                e_alusrc = Instr[25];
                if (Instr[25]) e_ext = ror_slow({24'd0, Instr[7:0]}, 2 * int'(Instr[11:8]));
                case (cmd)
                    4'b0100: e_alu = 3'd0;
                    4'b0010: e_alu = 3'd1;
                    4'b0000: e_alu = 3'd2;
                    4'b1100: e_alu = 3'd3;
                    4'b1101: e_alu = 3'd4;
                    4'b1010: begin e_alu = 3'd1; wr = 0; cmp = 1; end
                    default: begin e_alu = 3'd0; wr = 0; end
                endcase
                e_regw    = wr && pass;
                e_pcsrc   = e_regw && (rd == 4'd15);
                e_flagupd = pass && (cmp || (wr && Instr[20]));
            end
            2'b01: begin
                e_alusrc = 1;
                e_alu = Instr[23] ? 3'd0 : 3'd1;
                e_ext = {20'd0, Instr[11:0]};
                if (Instr[20]) begin
                    e_m2r = 1; e_regw = pass; e_pcsrc = pass && (rd == 4'd15);
                end else begin
                    e_memw = pass; ra2 = rd;
                end
            end
            2'b10: begin
                e_alusrc = 1; e_alu = 3'd0; e_pcsrc = pass;
                v = int'(Instr[23:0]);
                if (v >= 8388608) v = v - 16777216;
                e_ext = 32'(v * 4);
            end
            default: e_ctl_known = 0;
        endcase
        e_rd1 = rd_model(rn);
        e_rd2 = rd_model(ra2);
    endtask

    task automatic check_all(input string tag);
        model_eval();
        check({tag, ".RD1"}, RD1, e_rd1);
        check({tag, ".RD2"}, RD2, e_rd2);
        check({tag, ".ExtImm"}, ExtImm, e_ext);
        check({tag, ".RegWrite"}, 32'(RegWrite), 32'(e_regw));
        check({tag, ".MemWrite"}, 32'(MemWrite), 32'(e_memw));
        check({tag, ".MemtoReg"}, 32'(MemtoReg), 32'(e_m2r));
        check({tag, ".PCSrc"}, 32'(PCSrc), 32'(e_pcsrc));
        check({tag, ".CondEx"}, 32'(CondEx), 32'(e_cond));
        check({tag, ".Flags"}, 32'(Flags), 32'(m_flags));
        if (e_ctl_known) begin
            check({tag, ".ALUControl"}, 32'(ALUControl), 32'(e_alu));
            check({tag, ".ALUSrc"}, 32'(ALUSrc), 32'(e_alusrc));
        end
    endtask

    // Apply inputs just after an edge, then settle to the falling edge for checks.
    task automatic drive(input logic [31:0] ins, input logic we, input logic [3:0] wa,
                         input logic [31:0] wd, input logic [3:0] af);
        Instr = ins; WE3 = we; WA3 = wa; WD3 = wd; ALUFlags = af;
        @(negedge clk);
    endtask

    // Advance one rising edge and move the reference state with it.
    task automatic tick();
        bit do_flag, r, we;
        logic [3:0] wa, af;
        logic [31:0] wd;
        model_eval();
        do_flag = e_flagupd; r = reset; we = WE3; wa = WA3; wd = WD3; af = ALUFlags;
        @(posedge clk);
        if (r) begin
            for (int i = 0; i < 15; i++) m_rf[i] = 32'd0;
            m_flags = 4'd0;
        end else begin
            if (we && wa != 4'd15) m_rf[wa] = wd;
            if (do_flag) m_flags = af;
        end
        #1;
    endtask

    logic [3:0] dp_cmds [6] = '{4'b0100, 4'b0010, 4'b0000, 4'b1100, 4'b1101, 4'b1010};

    initial begin
        logic [31:0] ins;
        for (int i = 0; i < 15; i++) m_rf[i] = 32'd0;
        m_flags = 4'd0;

        // Reset together with a write to R3: reset must win.
        reset = 1'b1; PCPlus8 = 32'h0000_0008;
        Instr = 32'd0; WE3 = 1'b1; WA3 = 4'd3; WD3 = 32'd7; ALUFlags = 4'd0;
        @(negedge clk);
        tick();
        reset = 1'b0;

        drive(32'hE0824003, 1'b0, 4'd0, 32'd0, 4'd0);
        check("rst_RD1", RD1, 32'd0);
        check("rst_R3_RD2", RD2, 32'd0);
        check("rst_Flags", 32'(Flags), 32'd0);
        check("rst_RegWrite", 32'(RegWrite), 32'd1);
        check("rst_ALUControl", 32'(ALUControl), 32'd0);
        check_all("rst_add");
        tick();

        drive(32'h0000_0000, 1'b0, 4'd0, 32'd0, 4'd0);
        check("zero_CondEx", 32'(CondEx), 32'd0);
        check("zero_writes", {29'd0, RegWrite, MemWrite, PCSrc}, 32'd0);
        tick();

        drive(32'hE3A02005, 1'b1, 4'd2, 32'd5, 4'd0);
        check("mov_ExtImm", ExtImm, 32'd5);
        check("mov_ALUSrc", 32'(ALUSrc), 32'd1);
        check("mov_ALUControl", 32'(ALUControl), 32'd4);
        check("mov_RegWrite", 32'(RegWrite), 32'd1);
        tick();

        drive(32'hE0824003, 1'b1, 4'd2, 32'd9, 4'd0);
        check("wb_RD1_after", RD1, 32'd5);
        tick();
        drive(32'hE0824003, 1'b1, 4'd1, 32'h1234_ABCD, 4'd0);
        check("wb_RD1_newval", RD1, 32'd9);
        tick();

        drive(32'hE3A024FF, 1'b0, 4'd0, 32'd0, 4'd0);
        check("rot_ExtImm", ExtImm, 32'hFF00_0000);
        tick();

        PCPlus8 = 32'h0000_0010;
        drive(32'hE08F4003, 1'b1, 4'd15, 32'hDEAD_BEEF, 4'd0);
        check("r15_RD1", RD1, 32'h0000_0010);
        tick();
        drive(32'hE08F4003, 1'b0, 4'd0, 32'd0, 4'd0);
        check("r15_nowrite", RD1, 32'h0000_0010);
        check_all("r15");
        tick();

        drive(32'hE1520002, 1'b0, 4'd0, 32'd0, 4'b0100);
        check("cmp_RegWrite", 32'(RegWrite), 32'd0);
        check("cmp_CondEx", 32'(CondEx), 32'd1);
        tick();
        check("cmp_Flags", 32'(Flags), 32'h4);

        drive(32'h0A000002, 1'b0, 4'd0, 32'd0, 4'd0);
        check("beq_CondEx", 32'(CondEx), 32'd1);
        check("beq_PCSrc", 32'(PCSrc), 32'd1);
        check("beq_ExtImm", ExtImm, 32'd8);
        tick();
        drive(32'h1A000002, 1'b0, 4'd0, 32'd0, 4'd0);
        check("bne_PCSrc", 32'(PCSrc), 32'd0);
        tick();

        drive(32'hE5921004, 1'b0, 4'd0, 32'd0, 4'd0);
        check("ldr_MemtoReg", 32'(MemtoReg), 32'd1);
        check("ldr_RegWrite", 32'(RegWrite), 32'd1);
        check("ldr_ALUControl", 32'(ALUControl), 32'd0);
        check("ldr_ExtImm", ExtImm, 32'd4);
        tick();
        drive(32'hE5021004, 1'b0, 4'd0, 32'd0, 4'd0);
        check("str_MemWrite", 32'(MemWrite), 32'd1);
        check("str_ALUControl", 32'(ALUControl), 32'd1);
        check("str_RD2_R1", RD2, 32'h1234_ABCD);
        tick();

        drive(32'hF0824003, 1'b0, 4'd0, 32'd0, 4'd0);
        check("nv_CondEx", 32'(CondEx), 32'd0);
        check("nv_RegWrite", 32'(RegWrite), 32'd0);
        tick();

        // Mid-program reset clears flags (Z was set) and registers.
        reset = 1'b1;
        drive(32'hE0800001, 1'b0, 4'd0, 32'd0, 4'd0);
        tick();
        reset = 1'b0;
        drive(32'h0000_0000, 1'b0, 4'd0, 32'd0, 4'd0);
        check("mid_rst_Flags", 32'(Flags), 32'd0);
        check("mid_rst_CondEx", 32'(CondEx), 32'd0);
        check("mid_rst_writes", {29'd0, RegWrite, MemWrite, PCSrc}, 32'd0);
        tick();
        drive(32'hE0821001, 1'b0, 4'd0, 32'd0, 4'd0);
        check("mid_rst_R1", RD2, 32'd0);
        tick();

        // Randomized phase
        for (int n = 0; n < 500; n++) begin
            ins = $urandom;
            if ($urandom_range(0, 1) == 1) ins[31:28] = 4'hE;
            if (ins[27:26] == 2'b00 && $urandom_range(0, 3) != 0)
                ins[24:21] = dp_cmds[$urandom_range(0, 5)];
            reset   = ($urandom_range(0, 63) == 0);
            PCPlus8 = $urandom;
            drive(ins, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom,
                  4'($urandom_range(0, 15)));
            check_all("rand");
            tick();
        end
        reset = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
